// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/commit sequencer.
// Holds the FSM state encoding, datapath widths and the branch-resolution structs.
package fetch_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int CNT_W  = 32;

  localparam logic [PC_W-1:0] DEF_RESET_PC = 64'h0;
  localparam logic [PC_W-1:0] DEF_PC_INC   = 64'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } state_e;

  typedef struct packed {
    logic branch;
    logic uncond;
    logic zero;
  } br_ctl_t;

  typedef struct packed {
    logic            take;
    logic            misalign;
    logic [PC_W-1:0] target;
  } tgt_res_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [PC_W-1:0] a);
    return |a[1:0];
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC resolution: branch decision, target address and alignment check.
// Pure function of the current PC and the branch controls; no state.
module pc_target_calc
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_INC = DEF_PC_INC
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] imm,
  input  br_ctl_t         ctl,
  output tgt_res_t        res
);

  logic            take;
  logic [PC_W-1:0] target;

  always_comb begin
    take   = ctl.uncond | (ctl.branch & ctl.zero);
    // Both sums wrap modulo 2^PC_W by construction.
    target = take ? (pc + imm) : (pc + PC_INC);
  end

  always_comb begin
    res          = '0;
    res.take     = take;
    res.target   = target;
    res.misalign = is_misaligned(target);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/commit controller: owns the architectural PC, fetches one instruction per
// handshake, holds it for the core, and commits PC+4 or the branch target on done.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [PC_W-1:0] PC_INC   = DEF_PC_INC
) (
  input  logic              CLK,
  input  logic              Reset_L,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_done,
  input  logic              Branch,
  input  logic              Uncondbranch,
  input  logic              ALUZero,
  input  logic [PC_W-1:0]   SignExtImm64,
  input  logic              halt_req,
  output logic [PC_W-1:0]   CurrentPC,
  output logic [CNT_W-1:0]  retired,
  output logic              halted,
  output logic              fault
);

  state_e state_q, state_d;

  br_ctl_t  ctl;
  tgt_res_t res;

  logic              commit;
  logic              req_d;
  logic [INST_W-1:0] inst_d;
  logic              vld_d;
  logic [PC_W-1:0]   pc_d;
  logic [CNT_W-1:0]  ret_d;
  logic              halted_d;
  logic              fault_d;

  assign ctl.branch = Branch;
  assign ctl.uncond = Uncondbranch;
  assign ctl.zero   = ALUZero;

  pc_target_calc #(
    .PC_INC(PC_INC)
  ) u_tgt (
    .pc  (CurrentPC),
    .imm (SignExtImm64),
    .ctl (ctl),
    .res (res)
  );

  assign commit    = (state_q == EXEC) && inst_done;
  // imem_req is only ever high in REQ, where CurrentPC is stable.
  assign imem_addr = CurrentPC;

  always_ff @(posedge CLK) begin
    if (!Reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (imem_ack) state_d = EXEC;
      EXEC: begin
        if (inst_done) begin
          if (res.misalign)  state_d = FAULT;
          else if (halt_req) state_d = HALT;
          else               state_d = REQ;
        end
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Next values for every registered output; inputs never reach a port combinationally.
  always_comb begin
    req_d    = imem_req;
    inst_d   = inst;
    vld_d    = inst_valid;
    pc_d     = CurrentPC;
    ret_d    = retired;
    halted_d = halted;
    fault_d  = fault;
    case (state_q)
      IDLE: req_d = 1'b1;
      REQ: begin
        if (imem_ack) begin
          inst_d = imem_data;
          vld_d  = 1'b1;
          req_d  = 1'b0;
        end
      end
      EXEC: begin
        if (commit) begin
          vld_d = 1'b0;
          if (res.misalign) begin
            fault_d = 1'b1;
          end else begin
            pc_d  = res.target;
            ret_d = retired + CNT_W'(1);
            if (halt_req) halted_d = 1'b1;
            else          req_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      imem_req   <= 1'b0;
      inst       <= '0;
      inst_valid <= 1'b0;
      CurrentPC  <= RESET_PC;
      retired    <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      imem_req   <= req_d;
      inst       <= inst_d;
      inst_valid <= vld_d;
      CurrentPC  <= pc_d;
      retired    <= ret_d;
      halted     <= halted_d;
      fault      <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the driver predicts fetch addresses, captured
// words and post-commit state; a negedge monitor compares whenever the DUT presents them.
module tb_fetch_sequencer;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_done = 1'b0;
  logic        Branch = 1'b0, Uncondbranch = 1'b0, ALUZero = 1'b0;
  logic [63:0] SignExtImm64 = '0;
  logic        halt_req = 1'b0;
  logic [63:0] CurrentPC;
  logic [31:0] retired;
  logic        halted;
  logic        fault;

  fetch_sequencer #(.RESET_PC(RST_PC), .PC_INC(64'd4)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst(inst), .inst_valid(inst_valid), .inst_done(inst_done),
    .Branch(Branch), .Uncondbranch(Uncondbranch), .ALUZero(ALUZero),
    .SignExtImm64(SignExtImm64), .halt_req(halt_req),
    .CurrentPC(CurrentPC), .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ret;
    bit          halt;
    bit          flt;
    bit          req;
  } st_t;

  logic [63:0] exp_addr[$];
  logic [31:0] exp_inst[$];
  st_t         exp_state[$];

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] m_pc;
  logic [31:0] m_ret;
  bit          m_halt, m_flt;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endfunction

  function automatic void fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endfunction

  // Monitor
  bit chk_state = 0;
  always @(negedge CLK) begin
    if (chk_state) begin
      chk_state = 0;
      if (exp_state.size() == 0) fail_now("state_underflow");
      else begin
        st_t s;
        s = exp_state.pop_front();
        chk("commit_pc", CurrentPC, s.pc);
        chk("commit_retired", {32'h0, retired}, {32'h0, s.ret});
        chk("commit_halted", {63'h0, halted}, {63'h0, s.halt});
        chk("commit_fault", {63'h0, fault}, {63'h0, s.flt});
        chk("commit_req", {63'h0, imem_req}, {63'h0, s.req});
        chk("commit_valid", {63'h0, inst_valid}, 64'h0);
      end
    end
    if (Reset_L && imem_req) begin
      if (exp_addr.size() == 0) fail_now("unexpected_req");
      else begin
        chk("imem_addr", imem_addr, exp_addr[0]);
        if (imem_ack) void'(exp_addr.pop_front());
      end
    end
    if (Reset_L && inst_valid && inst_done) begin
      if (exp_inst.size() == 0) fail_now("unexpected_inst");
      else chk("inst", {32'h0, inst}, {32'h0, exp_inst.pop_front()});
      chk_state = 1;
    end
  end

  task automatic do_reset(input bit spur);
    Reset_L = 1'b0; inst_done = 1'b0; halt_req = 1'b0;
    imem_ack = spur; imem_data = $urandom;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    exp_addr.delete(); exp_inst.delete(); exp_state.delete();
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_inst", {32'h0, inst}, 64'h0);
    chk("rst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_pc", CurrentPC, RST_PC);
    chk("rst_retired", {32'h0, retired}, 64'h0);
    chk("rst_halted", {63'h0, halted}, 64'h0);
    chk("rst_fault", {63'h0, fault}, 64'h0);
    m_pc = RST_PC; m_ret = 0; m_halt = 0; m_flt = 0;
    exp_addr.push_back(m_pc);
    // A late ack is still present at the release edge; the DUT must ignore it.
    Reset_L = 1'b1;
    @(posedge CLK); #1;
    imem_ack = 1'b0;
  endtask

  task automatic do_inst(input int ack_dly, input int done_dly, input bit br, input bit ub,
                         input bit z, input logic [63:0] off, input bit hlt);
    int          n;
    logic [31:0] d;
    logic [63:0] tgt;
    n = 0;
    while (!imem_req) begin
      if (n > 50) begin fail_now("req_timeout"); return; end
      n++;
      @(posedge CLK); #1;
    end
    repeat (ack_dly) begin
      imem_data = $urandom; inst_done = 1'($urandom); halt_req = 1'($urandom);
      @(posedge CLK); #1;
    end
    d = $urandom;
    imem_data = d; imem_ack = 1'b1; inst_done = 1'($urandom);
    exp_inst.push_back(d);
    @(posedge CLK); #1;
    imem_ack = 1'b0; imem_data = $urandom; inst_done = 1'b0;
    repeat (done_dly) begin
      Branch = 1'($urandom); Uncondbranch = 1'($urandom); ALUZero = 1'($urandom);
      SignExtImm64 = {$urandom, $urandom}; halt_req = 1'($urandom); imem_ack = 1'($urandom);
      @(posedge CLK); #1;
    end
    imem_ack = 1'b0;
    Branch = br; Uncondbranch = ub; ALUZero = z; SignExtImm64 = off; halt_req = hlt;
    inst_done = 1'b1;
    tgt = (ub || (br && z)) ? m_pc + off : m_pc + 64'd4;
    if (tgt[1:0] != 2'b00) m_flt = 1;
    else begin
      m_pc = tgt;
      m_ret = m_ret + 1;
      if (hlt) m_halt = 1;
    end
    exp_state.push_back('{pc: m_pc, ret: m_ret, halt: m_halt, flt: m_flt, req: !(m_halt || m_flt)});
    if (!m_halt && !m_flt) exp_addr.push_back(m_pc);
    @(posedge CLK); #1;
    inst_done = 1'b0; halt_req = 1'b0;
    Branch = 1'($urandom); Uncondbranch = 1'($urandom); ALUZero = 1'($urandom);
    SignExtImm64 = {$urandom, $urandom};
  endtask

  // Terminal states: hammer every input and confirm nothing moves.
  task automatic probe_terminal(input int cycles);
    repeat (cycles) begin
      imem_ack = 1'b1; imem_data = $urandom; inst_done = 1'b1; halt_req = 1'($urandom);
      Uncondbranch = 1'b1; SignExtImm64 = 64'h40;
      @(posedge CLK); #1;
      chk("term_req", {63'h0, imem_req}, 64'h0);
      chk("term_valid", {63'h0, inst_valid}, 64'h0);
      chk("term_pc", CurrentPC, m_pc);
      chk("term_retired", {32'h0, retired}, {32'h0, m_ret});
      chk("term_halted", {63'h0, halted}, {63'h0, m_halt});
      chk("term_fault", {63'h0, fault}, {63'h0, m_flt});
    end
    imem_ack = 1'b0; inst_done = 1'b0; halt_req = 1'b0; Uncondbranch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(1'b0);
    // Back-to-back zero-wait fetches: 0x0, 0x4, 0x8.
    repeat (3) do_inst(0, 0, 0, 0, 0, 64'h0, 0);
    chk("retired_after_3", {32'h0, retired}, 64'd3);

    // Mid-REQ reset with a spurious ack, then restart at RESET_PC.
    do_reset(1'b1);
    do_inst(0, 0, 0, 1, 0, 64'h10, 0);
    do_inst(3, 1, 0, 0, 0, 64'h0, 0);

    // Taken conditional branch from 0x20 back to 0x18.
    do_reset(1'b0);
    do_inst(0, 0, 0, 1, 0, 64'h20, 0);
    do_inst(1, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    chk("br_taken_pc", CurrentPC, 64'h18);

    // Not-taken conditional branch from 0x20 falls through to 0x24.
    do_reset(1'b0);
    do_inst(0, 0, 0, 1, 0, 64'h20, 0);
    do_inst(0, 2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    chk("br_nottaken_pc", CurrentPC, 64'h24);

    // Misaligned unconditional target faults.
    do_reset(1'b0);
    do_inst(0, 0, 0, 0, 0, 64'h0, 0);
    do_inst(2, 0, 0, 1, 0, 64'h6, 0);
    probe_terminal(4);

    // Halt together with done at 0x8 commits to 0xC then stops.
    do_reset(1'b0);
    do_inst(0, 0, 0, 1, 0, 64'h8, 0);
    do_inst(1, 1, 0, 0, 0, 64'h0, 1);
    chk("halt_pc", CurrentPC, 64'hC);
    probe_terminal(4);

    // Randomized run with aligned offsets, ending in a halt.
    do_reset(1'b1);
    for (int i = 0; i < 40; i++) begin
      logic [63:0] off;
      bit          ub;
      off = 64'(signed'(32'($urandom_range(0, 32)) - 32'sd16)) << 2;
      ub  = ($urandom_range(0, 3) == 0);
      do_inst($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), ub, 1'($urandom),
              off, i == 39);
    end
    probe_terminal(3);

    @(posedge CLK); #1;
    chk("queues_drained", 64'(exp_addr.size() + exp_inst.size() + exp_state.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
